booth_datapath: RTL and testbench
=================================

BOOTH_DATAPATH -- requirements
Module: booth_datapath

Interface
REQ-001 The block SHALL have one clock and an asynchronous, active-high reset.
REQ-002 The ports SHALL be as follows, one per line: name, direction, width, meaning.
- clk  input  1  rising-edge clock
- rst  input  1  asynchronous active-high reset
- inbus  input  8  signed operand bus; multiplicand sampled on c0, multiplier sampled on c1
- c0  input  1  load M from inbus; clear A
- c1  input  1  load Q from inbus; clear Qm1 and cnt
- c2  input  1  add step: A <= A + operand
- c3  input  1  operand is 2M (else M); valid only with c2
- c4  input  1  subtract operand (else add); valid only with c2
- c5  input  1  arithmetic shift right by 2; cnt increments
- c6  input  1  latch product into prod
- q1, q0, q  output  1 each  Q[1], Q[0], Qm1; the Booth recode bits for the controller
- is_count_3  output  1  high while cnt == 3
- prod  output  16  signed product register

Function
REQ-003 Internal registers SHALL be: A 10-bit signed, Q 8-bit, Qm1 1-bit, M 8-bit signed, cnt 2-bit, prod 16-bit.
REQ-004 On c0, the block SHALL set M <= inbus and A <= 0.
REQ-005 On c1, the block SHALL set Q <= inbus, Qm1 <= 0 and cnt <= 0.
REQ-006 On c2, the block SHALL update A <= A +/- op.
- op = sign-extended M, or sign-extended {M,1'b0} when c3 = 1.
- Subtraction is selected by c4 = 1.
- All arithmetic is 10-bit two's complement; no overflow is possible for 8-bit operands.
REQ-007 On c5, the block SHALL perform the following in one cycle:
- Qm1 <= Q[1]
- Q <= {A[1:0], Q[7:2]}
- A <= {A[9], A[9], A[9:2]}
- cnt <= cnt + 1, wrapping 3 -> 0
REQ-008 On c6, the block SHALL set prod <= {A[7:0], Q}; prod holds its value until the next c6 or reset.
REQ-009 The outputs q1, q0, q and is_count_3 SHALL be combinational decodes of registered state only (zero latency from the register update).
REQ-010 A full multiply SHALL follow this sequence:
- c0, then c1
- four iterations of an optional c2 followed by c5
- then c6
- Result: prod = signed(M) * signed(multiplier).
REQ-011 Priority when more than one strobe is asserted in the same cycle SHALL be c0 > c1 > c2 > c5 > c6; only the highest-priority strobe acts.
REQ-012 When c3 or c4 is asserted without c2, the block SHALL ignore it.
REQ-013 With no strobe asserted, all registers SHALL hold.
REQ-014 The block SHALL contain no internal FSM; all sequencing comes from the controller.

Reset
REQ-015 Asserting rst SHALL immediately clear A, Q, Qm1, M, cnt and prod to 0, independent of clk.
REQ-016 Reset asserted mid-operation SHALL abort the multiply; the next multiply SHALL begin with c0.
REQ-017 Strobes SHALL be ignored while rst = 1.

Configuration
REQ-018 With macro BOOTH_CTRL_CHECK_EN defined, the block SHALL add output err (1-bit, reset 0).
- err is sticky and set on any of:
  - more than one of c0, c1, c2, c5, c6 asserted in the same cycle;
  - c3 or c4 asserted without c2;
  - c2 asserted while c3 = 1 and q1, q0, q = 3'b000 or 3'b111.
- err clears only on rst.
- Datapath behaviour is unchanged.
REQ-019 Without BOOTH_CTRL_CHECK_EN, the err port and its logic SHALL be absent.

Verification
REQ-020 The bench SHALL cover the following directed scenarios:
- M = 7, multiplier = 3, Booth-correct strobe sequence -> prod = 16'h0015; is_count_3 high during the 4th iteration only.
- M = -128, multiplier = -128 -> prod = 16'h4000.
- M = -5, multiplier = 6 -> prod = 16'hFFE2; intermediate A matches the hand trace after each c5.
- M = 0x55, multiplier = 0 (no c2 in any iteration) -> prod = 0; cnt wraps to 0 after the 4th c5.
- rst pulsed between the 2nd and 3rd c5 -> all registers 0 asynchronously; a following multiply 3*(-4) -> prod = 16'hFFF4.
- With BOOTH_CTRL_CHECK_EN: c2 and c5 in the same cycle -> only the c2 add applies; err = 1 and stays 1 until rst.

Source files
------------

// File: rtl/booth_datapath.sv
// booth_datapath -- radix-4 Booth multiplier datapath, 8x8 signed -> 16-bit.
//
// This block only holds the datapath. An external controller sequences it
// with one strobe per cycle. The controller uses the Booth recode bits
// (q1, q0, q) and is_count_3 to choose the next strobe.
//
// Ports:
//   clk         rising-edge clock
//   rst         asynchronous active-high reset; clears every register
//   inbus[7:0]  signed operand bus (multiplicand on c0, multiplier on c1)
//   c0          M <= inbus, A <= 0
//   c1          Q <= inbus, Qm1 <= 0, cnt <= 0
//   c2          A <= A +/- op
//   c3          op = 2M instead of M (only with c2)
//   c4          subtract instead of add (only with c2)
//   c5          arithmetic shift right by 2 of {A,Q,Qm1}; cnt++
//   c6          prod <= {A[7:0], Q}
//   q1, q0, q   Q[1], Q[0], Qm1 (Booth recode bits)
//   is_count_3  cnt == 3
//   prod[15:0]  signed product register
//   err         (only with BOOTH_CTRL_CHECK_EN) sticky strobe-protocol error
//
// Optional feature macro: BOOTH_CTRL_CHECK_EN adds the err output and its
// protocol checker. The datapath behaviour is the same with or without it.
// Strobe priority when several are asserted: c0 > c1 > c2 > c5 > c6.

module booth_datapath (
    input  logic               clk,
    input  logic               rst,
    input  logic signed [7:0]  inbus,
    input  logic               c0,
    input  logic               c1,
    input  logic               c2,
    input  logic               c3,
    input  logic               c4,
    input  logic               c5,
    input  logic               c6,
    output logic               q1,
    output logic               q0,
    output logic               q,
    output logic               is_count_3,
    output logic signed [15:0] prod
`ifdef BOOTH_CTRL_CHECK_EN
    ,
    output logic               err
`endif
);

    localparam int DATA_W = 8;
    localparam int ACC_W  = DATA_W + 2;   // headroom for +/-2M without overflow
    localparam int PROD_W = 2 * DATA_W;

    logic signed [ACC_W-1:0]  a_q, a_d;
    logic        [DATA_W-1:0] q_q, q_d;
    logic                     qm1_q, qm1_d;
    logic signed [DATA_W-1:0] m_q, m_d;
    logic        [1:0]        cnt_q, cnt_d;
    logic signed [PROD_W-1:0] prod_q, prod_d;

    // Sign-extended multiplicand, optionally doubled.
    function automatic logic signed [ACC_W-1:0] booth_operand(
        input logic signed [DATA_W-1:0] m,
        input logic                     dbl
    );
        if (dbl) return {m[DATA_W-1], m, 1'b0};
        else     return {{2{m[DATA_W-1]}}, m};
    endfunction

    // Two's-complement add/subtract in ACC_W bits. Operands of at most 2*|M|
    // on an accumulator that has already been shifted cannot overflow.
    function automatic logic signed [ACC_W-1:0] acc_add_sub(
        input logic signed [ACC_W-1:0] acc,
        input logic signed [ACC_W-1:0] op,
        input logic                    sub
    );
        return sub ? (acc - op) : (acc + op);
    endfunction

    always_comb begin
        a_d    = a_q;
        q_d    = q_q;
        qm1_d  = qm1_q;
        m_d    = m_q;
        cnt_d  = cnt_q;
        prod_d = prod_q;
        if (c0) begin
            m_d = inbus;
            a_d = '0;
        end else if (c1) begin
            q_d   = inbus;
            qm1_d = 1'b0;
            cnt_d = 2'd0;
        end else if (c2) begin
            a_d = acc_add_sub(a_q, booth_operand(m_q, c3), c4);
        end else if (c5) begin
            // {A,Q,Qm1} shifts right by 2 arithmetically as one long register.
            qm1_d = q_q[1];
            q_d   = {a_q[1:0], q_q[DATA_W-1:2]};
            a_d   = {a_q[ACC_W-1], a_q[ACC_W-1], a_q[ACC_W-1:2]};
            cnt_d = cnt_q + 2'd1;
        end else if (c6) begin
            prod_d = {a_q[DATA_W-1:0], q_q};
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            a_q    <= '0;
            q_q    <= '0;
            qm1_q  <= 1'b0;
            m_q    <= '0;
            cnt_q  <= 2'd0;
            prod_q <= '0;
        end else begin
            a_q    <= a_d;
            q_q    <= q_d;
            qm1_q  <= qm1_d;
            m_q    <= m_d;
            cnt_q  <= cnt_d;
            prod_q <= prod_d;
        end
    end

    assign q1         = q_q[1];
    assign q0         = q_q[0];
    assign q          = qm1_q;
    assign is_count_3 = (cnt_q == 2'd3);
    assign prod       = prod_q;

`ifdef BOOTH_CTRL_CHECK_EN
    logic err_q, err_d;
    logic multi_strobe;
    logic orphan_mod;
    logic useless_dbl;

    always_comb begin
        multi_strobe = ($countones({c0, c1, c2, c5, c6}) > 1);
        orphan_mod   = (c3 | c4) & ~c2;
        // A 2M step is only meaningful for recodes 011/100; 000 and 111 mean
        // "no operation", so a 2M add there points to a controller bug.
        useless_dbl  = c2 & c3 & (({q_q[1], q_q[0], qm1_q} == 3'b000) ||
                                  ({q_q[1], q_q[0], qm1_q} == 3'b111));
        err_d        = err_q | multi_strobe | orphan_mod | useless_dbl;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) err_q <= 1'b0;
        else     err_q <= err_d;
    end

    assign err = err_q;
`endif

endmodule

// File: tb/tb_booth_datapath.sv
// Directed bench for booth_datapath: Booth strobe sequences with hand-traced
// expected products, recode bits, counter and accumulator values.
module tb_booth_datapath;

    logic        clk;
    logic        rst;
    logic [7:0]  inbus;
    logic        c0, c1, c2, c3, c4, c5, c6;
    logic        q1, q0, q, is_count_3;
    logic [15:0] prod;
`ifdef BOOTH_CTRL_CHECK_EN
    logic        err;
`endif

    int n_tests = 0;
    int n_fail  = 0;

    localparam logic [6:0] C0 = 7'b0000001;
    localparam logic [6:0] C1 = 7'b0000010;
    localparam logic [6:0] C2 = 7'b0000100;
    localparam logic [6:0] C3 = 7'b0001000;
    localparam logic [6:0] C4 = 7'b0010000;
    localparam logic [6:0] C5 = 7'b0100000;
    localparam logic [6:0] C6 = 7'b1000000;
    localparam logic [6:0] NOP    = 7'b0000000;
    localparam logic [6:0] ADD_M  = C2;
    localparam logic [6:0] ADD_2M = C2 | C3;
    localparam logic [6:0] SUB_M  = C2 | C4;
    localparam logic [6:0] SUB_2M = C2 | C3 | C4;

    booth_datapath dut (
        .clk        (clk),
        .rst        (rst),
        .inbus      (inbus),
        .c0         (c0),
        .c1         (c1),
        .c2         (c2),
        .c3         (c3),
        .c4         (c4),
        .c5         (c5),
        .c6         (c6),
        .q1         (q1),
        .q0         (q0),
        .q          (q),
        .is_count_3 (is_count_3),
        .prod       (prod)
`ifdef BOOTH_CTRL_CHECK_EN
        ,
        .err        (err)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Drive a strobe vector for exactly one rising edge; returns 1 time unit
    // after that edge with all strobes low again.
    task automatic strobe(input logic [6:0] s, input logic [7:0] d);
        {c6, c5, c4, c3, c2, c1, c0} = s;
        inbus = d;
        @(posedge clk);
        #1;
        {c6, c5, c4, c3, c2, c1, c0} = NOP;
    endtask

    // One Booth iteration: verify the recode bits and count flag the
    // controller would see, then apply the optional add step and the shift.
    task automatic booth_iter(input string tag, input logic [2:0] rec_exp,
                              input logic cnt3_exp, input logic [6:0] op);
        check_eq({tag, ".rec"}, {29'd0, q1, q0, q}, {29'd0, rec_exp});
        check_eq({tag, ".cnt3"}, {31'd0, is_count_3}, {31'd0, cnt3_exp});
        if (op != NOP) strobe(op, 8'h00);
        strobe(C5, 8'h00);
    endtask

    initial begin
        rst   = 1'b0;
        inbus = 8'h00;
        {c6, c5, c4, c3, c2, c1, c0} = NOP;
        #1 rst = 1'b1;
        #2;
        check_eq("reset.prod", {16'd0, prod}, 32'h0);
        check_eq("reset.rec", {29'd0, q1, q0, q}, 32'h0);
        check_eq("reset.cnt3", {31'd0, is_count_3}, 32'h0);
        check_eq("reset.a", {22'd0, $unsigned(dut.a_q)}, 32'h0);
        @(posedge clk);
        #1 rst = 1'b0;

        // 7 * 3 = 21
        strobe(C0, 8'd7);
        strobe(C1, 8'd3);
        booth_iter("s1.i1", 3'b110, 1'b0, SUB_M);
        check_eq("s1.a1", {22'd0, $unsigned(dut.a_q)}, 32'h3FE);
        booth_iter("s1.i2", 3'b001, 1'b0, ADD_M);
        booth_iter("s1.i3", 3'b000, 1'b0, NOP);
        booth_iter("s1.i4", 3'b000, 1'b1, NOP);
        check_eq("s1.cnt3_after", {31'd0, is_count_3}, 32'h0);
        strobe(C6, 8'h00);
        check_eq("s1.prod", {16'd0, prod}, 32'h0015);

        // -128 * -128 = 16384
        strobe(C0, 8'h80);
        strobe(C1, 8'h80);
        booth_iter("s2.i1", 3'b000, 1'b0, NOP);
        booth_iter("s2.i2", 3'b000, 1'b0, NOP);
        booth_iter("s2.i3", 3'b000, 1'b0, NOP);
        booth_iter("s2.i4", 3'b100, 1'b1, SUB_2M);
        strobe(C6, 8'h00);
        check_eq("s2.prod", {16'd0, prod}, 32'h4000);

        // 0x55 * 0, no add steps; counter wraps
        strobe(C0, 8'h55);
        strobe(C1, 8'h00);
        booth_iter("s4.i1", 3'b000, 1'b0, NOP);
        booth_iter("s4.i2", 3'b000, 1'b0, NOP);
        booth_iter("s4.i3", 3'b000, 1'b0, NOP);
        check_eq("s4.cnt_at3", {30'd0, dut.cnt_q}, 32'd3);
        booth_iter("s4.i4", 3'b000, 1'b1, NOP);
        check_eq("s4.cnt_wrap", {30'd0, dut.cnt_q}, 32'd0);
        check_eq("s4.cnt3_after", {31'd0, is_count_3}, 32'h0);
        strobe(C6, 8'h00);
        check_eq("s4.prod", {16'd0, prod}, 32'h0);

        // -5 * 6 = -30 with accumulator trace after each shift
        strobe(C0, 8'hFB);
        strobe(C1, 8'h06);
        booth_iter("s3.i1", 3'b100, 1'b0, SUB_2M);
        check_eq("s3.a1", {22'd0, $unsigned(dut.a_q)}, 32'h002);
        booth_iter("s3.i2", 3'b011, 1'b0, ADD_2M);
        check_eq("s3.a2", {22'd0, $unsigned(dut.a_q)}, 32'h3FE);
        booth_iter("s3.i3", 3'b000, 1'b0, NOP);
        check_eq("s3.a3", {22'd0, $unsigned(dut.a_q)}, 32'h3FF);
        booth_iter("s3.i4", 3'b000, 1'b1, NOP);
        check_eq("s3.a4", {22'd0, $unsigned(dut.a_q)}, 32'h3FF);
        check_eq("s3.q4", {24'd0, dut.q_q}, 32'hE2);
        strobe(C6, 8'h00);
        check_eq("s3.prod", {16'd0, prod}, 32'hFFE2);

        // Abort mid-multiply with an asynchronous reset
        strobe(C0, 8'hFB);
        strobe(C1, 8'h06);
        booth_iter("s5.i1", 3'b100, 1'b0, SUB_2M);
        booth_iter("s5.i2", 3'b011, 1'b0, ADD_2M);
        #2 rst = 1'b1;
        #1;
        check_eq("s5.rst.prod", {16'd0, prod}, 32'h0);
        check_eq("s5.rst.a", {22'd0, $unsigned(dut.a_q)}, 32'h0);
        check_eq("s5.rst.q", {24'd0, dut.q_q}, 32'h0);
        check_eq("s5.rst.m", {24'd0, $unsigned(dut.m_q)}, 32'h0);
        check_eq("s5.rst.cnt", {30'd0, dut.cnt_q}, 32'h0);
        check_eq("s5.rst.rec", {29'd0, q1, q0, q}, 32'h0);
        // strobes while reset is held must have no effect
        strobe(C0, 8'h7F);
        check_eq("s5.rst.ignore_m", {24'd0, $unsigned(dut.m_q)}, 32'h0);
        rst = 1'b0;
        strobe(C0, 8'd3);
        strobe(C1, 8'hFC);
        booth_iter("s5.i1b", 3'b000, 1'b0, NOP);
        booth_iter("s5.i2b", 3'b110, 1'b0, SUB_M);
        booth_iter("s5.i3b", 3'b111, 1'b0, NOP);
        booth_iter("s5.i4b", 3'b111, 1'b1, NOP);
        strobe(C6, 8'h00);
        check_eq("s5.prod", {16'd0, prod}, 32'hFFF4);

        // Priority and ignored modifiers
        strobe(C0 | C1, 8'h12);
        check_eq("pri.c0c1.m", {24'd0, $unsigned(dut.m_q)}, 32'h12);
        check_eq("pri.c0c1.q", {24'd0, dut.q_q}, 32'hF4);
        strobe(C3 | C4, 8'h00);
        check_eq("pri.c3c4.a", {22'd0, $unsigned(dut.a_q)}, 32'h0);
        strobe(C2 | C5, 8'h00);
        check_eq("pri.c2c5.a", {22'd0, $unsigned(dut.a_q)}, 32'h012);
        check_eq("pri.c2c5.q", {24'd0, dut.q_q}, 32'hF4);
        check_eq("pri.c2c5.cnt", {30'd0, dut.cnt_q}, 32'd0);
        strobe(C5 | C6, 8'h00);
        check_eq("pri.c5c6.a", {22'd0, $unsigned(dut.a_q)}, 32'h004);
        check_eq("pri.c5c6.q", {24'd0, dut.q_q}, 32'hBD);
        check_eq("pri.c5c6.prod", {16'd0, prod}, 32'hFFF4);
        check_eq("pri.c5c6.cnt", {30'd0, dut.cnt_q}, 32'd1);

`ifdef BOOTH_CTRL_CHECK_EN
        #2 rst = 1'b1;
        #2 rst = 1'b0;
        check_eq("err.after_rst", {31'd0, err}, 32'h0);
        strobe(C0, 8'd5);
        strobe(C1, 8'h01);
        check_eq("err.clean_seq", {31'd0, err}, 32'h0);
        strobe(C2 | C5, 8'h00);
        check_eq("err.c2c5.a", {22'd0, $unsigned(dut.a_q)}, 32'h005);
        check_eq("err.c2c5.cnt", {30'd0, dut.cnt_q}, 32'd0);
        check_eq("err.set", {31'd0, err}, 32'h1);
        strobe(NOP, 8'h00);
        strobe(NOP, 8'h00);
        check_eq("err.sticky", {31'd0, err}, 32'h1);
        #2 rst = 1'b1;
        #1;
        check_eq("err.cleared", {31'd0, err}, 32'h0);
        rst = 1'b0;
`endif

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
